// File: rtl/mips16_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mips16_muldiv                                                   |
// | Purpose  : Multi-cycle radix-2 multiply/divide unit owning HI/LO for the   |
// |            mips16_sc core (shift-add multiply, restoring divide).          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mips16_muldiv #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 5
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             write_hi,
   input  logic             write_lo,
   input  logic [WIDTH-1:0] wdata,
   input  logic             hi_lo_sl,
   output logic [WIDTH-1:0] hi_lo_out,
   output logic             instr_stall_sl,
   output logic             ready,
   output logic             div_zero,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                 r_state, w_next;
   logic [CNT_W-1:0]       r_cnt;
   logic [1:0]             r_op;
   logic                   r_sign_a, r_sign_b, r_dz;
   logic [WIDTH-1:0]       r_a_raw;
   logic [WIDTH-1:0]       r_opnd;
   logic [2*WIDTH-1:0]     r_acc;
   logic [WIDTH-1:0]       r_hi, r_lo;

   logic                   w_open, w_accept;
   logic                   w_sign_a_in, w_sign_b_in;
   logic [WIDTH-1:0]       w_mag_a_in, w_mag_b_in;
   logic [WIDTH:0]         w_mul_sum, w_div_trial, w_div_diff;
   logic [2*WIDTH-1:0]     w_step, w_prod_neg;
   logic [WIDTH-1:0]       w_q, w_rem, w_fix_hi, w_fix_lo;

   assign w_open   = (r_state == S_IDLE) || (r_state == S_DONE);
   assign w_accept = start && w_open;

   assign w_sign_a_in = ~op[0] & a[WIDTH-1];
   assign w_sign_b_in = ~op[0] & b[WIDTH-1];
   assign w_mag_a_in  = w_sign_a_in ? (~a + WIDTH'(1)) : a;
   assign w_mag_b_in  = w_sign_b_in ? (~b + WIDTH'(1)) : b;

   // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient};
   // r_opnd holds the multiplicand or divisor magnitude.
   always_comb begin
      w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
      w_div_trial = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
      w_div_diff  = w_div_trial - {1'b0, r_opnd};
      if (r_op[1]) begin
         w_step = {(w_div_diff[WIDTH] ? w_div_trial[WIDTH-1:0] : w_div_diff[WIDTH-1:0]),
                   r_acc[WIDTH-2:0], ~w_div_diff[WIDTH]};
      end else begin
         w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
      end
   end

   always_comb begin
      w_prod_neg = ~r_acc + (2*WIDTH)'(1);
      w_q        = r_acc[WIDTH-1:0];
      w_rem      = r_acc[2*WIDTH-1:WIDTH];
      w_fix_hi   = w_rem;
      w_fix_lo   = w_q;
      if (r_dz) begin
         w_fix_hi = r_a_raw;
         w_fix_lo = '1;
      end else if (r_op[1]) begin
         // Quotient sign from both operands, remainder follows the dividend.
         w_fix_lo = (r_sign_a ^ r_sign_b) ? (~w_q + WIDTH'(1)) : w_q;
         w_fix_hi = r_sign_a ? (~w_rem + WIDTH'(1)) : w_rem;
      end else if (r_sign_a ^ r_sign_b) begin
         {w_fix_hi, w_fix_lo} = w_prod_neg;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: w_next = start ? S_CALC : S_IDLE;
         S_CALC:         if (r_cnt == CNT_W'(WIDTH-1)) w_next = S_FIX;
         S_FIX:          w_next = S_DONE;
         default:        w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_op     <= '0;
         r_sign_a <= 1'b0;
         r_sign_b <= 1'b0;
         r_dz     <= 1'b0;
         r_a_raw  <= '0;
         r_opnd   <= '0;
         r_acc    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         if (w_accept) begin
            r_cnt    <= '0;
            r_op     <= op;
            r_sign_a <= w_sign_a_in;
            r_sign_b <= w_sign_b_in;
            r_dz     <= op[1] && (b == '0);
            r_a_raw  <= a;
            r_opnd   <= op[1] ? w_mag_b_in : w_mag_a_in;
            r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_mag_a_in : w_mag_b_in)};
         end else if (w_open) begin
            if (write_hi) r_hi <= wdata;
            if (write_lo) r_lo <= wdata;
         end else if (r_state == S_CALC) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CNT_W'(1);
         end else if (r_state == S_FIX) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
         end
      end
   end

   assign busy           = (r_state == S_CALC) || (r_state == S_FIX);
   assign ready          = (r_state == S_DONE);
   assign div_zero       = (r_state == S_DONE) && r_dz;
   assign instr_stall_sl = busy || w_accept;
   assign hi_lo_out      = hi_lo_sl ? r_hi : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips16_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mips16_muldiv                                                |
// | Purpose  : Directed self-checking bench for mips16_muldiv.                 |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_mips16_muldiv;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [15:0] a = '0, b = '0, wdata = '0;
   logic        write_hi = 1'b0, write_lo = 1'b0, hi_lo_sl = 1'b0;
   logic [15:0] hi_lo_out;
   logic        instr_stall_sl, ready, div_zero, busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   mips16_muldiv #(.WIDTH(16), .CNT_W(5)) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
      .write_hi(write_hi), .write_lo(write_lo), .wdata(wdata), .hi_lo_sl(hi_lo_sl),
      .hi_lo_out(hi_lo_out), .instr_stall_sl(instr_stall_sl), .ready(ready),
      .div_zero(div_zero), .busy(busy)
   );

   // Issues one operation and returns just after the negedge where ready is seen.
   task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         output int lat, output int stalls, output logic dz);
      @(negedge clock);
      start = 1'b1; op = o; a = x; b = y;
      #1 stalls = instr_stall_sl ? 1 : 0;
      @(negedge clock);
      start = 1'b0; a = 16'h5A5A; b = 16'h5A5A;
      #1 lat = 0;
      while (ready !== 1'b1 && lat < 40) begin
         if (instr_stall_sl) stalls++;
         @(negedge clock);
         #1 lat++;
      end
      dz = div_zero;
   endtask

   task automatic test_reset;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (ready !== 1'b0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b/%b want 0/0", ready, div_zero); end
      n_checks++; if (instr_stall_sl !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %b want 0", instr_stall_sl); end
      hi_lo_sl = 1'b1; #1;
      n_checks++; if (hi_lo_out !== 16'h0000) begin n_fail++; $display("FAIL reset_hi got %h want 0000", hi_lo_out); end
      hi_lo_sl = 1'b0; #1;
      n_checks++; if (hi_lo_out !== 16'h0000) begin n_fail++; $display("FAIL reset_lo got %h want 0000", hi_lo_out); end
      @(negedge clock); reset_n = 1'b1;
   endtask

   // Runs one op and checks latency, stall count, result and ready/div_zero pulse widths.
   task automatic check_op(input string nm, input logic [1:0] o, input logic [15:0] x,
                           input logic [15:0] y, input logic [15:0] ehi, input logic [15:0] elo,
                           input logic edz);
      int lat, stalls;
      logic dz;
      run_op(o, x, y, lat, stalls, dz);
      n_checks++; if (lat !== 17) begin n_fail++; $display("FAIL %s_latency got %0d want 17", nm, lat); end
      n_checks++; if (stalls !== 18) begin n_fail++; $display("FAIL %s_stalls got %0d want 18", nm, stalls); end
      n_checks++; if (dz !== edz) begin n_fail++; $display("FAIL %s_div_zero got %b want %b", nm, dz, edz); end
      hi_lo_sl = 1'b1; #1;
      n_checks++; if (hi_lo_out !== ehi) begin n_fail++; $display("FAIL %s_hi got %h want %h", nm, hi_lo_out, ehi); end
      hi_lo_sl = 1'b0; #1;
      n_checks++; if (hi_lo_out !== elo) begin n_fail++; $display("FAIL %s_lo got %h want %h", nm, hi_lo_out, elo); end
      @(negedge clock); #1;
      n_checks++; if (ready !== 1'b0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL %s_pulse got %b/%b want 0/0", nm, ready, div_zero); end
   endtask

   task automatic test_mult;
      check_op("multu_max", 2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0);
      check_op("mult_neg",  2'b00, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0);
      check_op("mult_min",  2'b00, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0);
   endtask

   task automatic test_div;
      check_op("div_neg",   2'b10, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0);
      check_op("divu",      2'b11, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0);
      check_op("divu_zero", 2'b11, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1);
      check_op("div_zero",  2'b10, 16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1);
      check_op("div_ovf",   2'b10, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0);
   endtask

   task automatic test_busy_ignore;
      int idx;
      @(negedge clock);
      start = 1'b1; op = 2'b01; a = 16'h1234; b = 16'h0056;
      @(negedge clock);
      start = 1'b0; idx = 0;
      #1;
      while (ready !== 1'b1 && idx < 40) begin
         if (idx == 4) begin start = 1'b1; op = 2'b01; a = 16'h0002; b = 16'h0003; end
         if (idx == 5) start = 1'b0;
         if (idx == 7) begin write_hi = 1'b1; wdata = 16'h5555; end
         if (idx == 8) write_hi = 1'b0;
         if (idx == 7) begin
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_flag got %b want 1", busy); end
         end
         @(negedge clock);
         #1 idx++;
      end
      n_checks++; if (idx !== 17) begin n_fail++; $display("FAIL busy_latency got %0d want 17", idx); end
      hi_lo_sl = 1'b1; #1;
      n_checks++; if (hi_lo_out !== 16'h0006) begin n_fail++; $display("FAIL busy_hi got %h want 0006", hi_lo_out); end
      hi_lo_sl = 1'b0; #1;
      n_checks++; if (hi_lo_out !== 16'h1D78) begin n_fail++; $display("FAIL busy_lo got %h want 1d78", hi_lo_out); end
   endtask

   task automatic test_move_to;
      @(negedge clock); @(negedge clock);
      write_lo = 1'b1; wdata = 16'hABCD;
      @(negedge clock);
      write_lo = 1'b0; hi_lo_sl = 1'b0;
      #1;
      n_checks++; if (hi_lo_out !== 16'hABCD) begin n_fail++; $display("FAIL mtlo_lo got %h want abcd", hi_lo_out); end
      hi_lo_sl = 1'b1; #1;
      n_checks++; if (hi_lo_out !== 16'h0006) begin n_fail++; $display("FAIL mtlo_hi got %h want 0006", hi_lo_out); end
      write_hi = 1'b1; wdata = 16'h0F0F;
      @(negedge clock);
      write_hi = 1'b0; #1;
      n_checks++; if (hi_lo_out !== 16'h0F0F) begin n_fail++; $display("FAIL mthi_hi got %h want 0f0f", hi_lo_out); end
   endtask

   task automatic test_reset_abort;
      @(negedge clock);
      start = 1'b1; op = 2'b10; a = 16'h0100; b = 16'h0003;
      @(negedge clock);
      start = 1'b0;
      repeat (8) @(negedge clock);
      @(posedge clock);
      #1 reset_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
      n_checks++; if (instr_stall_sl !== 1'b0) begin n_fail++; $display("FAIL abort_stall got %b want 0", instr_stall_sl); end
      hi_lo_sl = 1'b1; #1;
      n_checks++; if (hi_lo_out !== 16'h0000) begin n_fail++; $display("FAIL abort_hi got %h want 0000", hi_lo_out); end
      hi_lo_sl = 1'b0; #1;
      n_checks++; if (hi_lo_out !== 16'h0000) begin n_fail++; $display("FAIL abort_lo got %h want 0000", hi_lo_out); end
      @(negedge clock);
      reset_n = 1'b1;
      check_op("after_reset", 2'b11, 16'd100, 16'd7, 16'h0002, 16'h000E, 1'b0);
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_busy_ignore;
      test_move_to;
      test_reset_abort;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
